// File: rtl/alu_seq_flags.sv
//------------------------------------------------------------------------------
// alu_seq_flags : accumulator ALU with E/Z/N/V flags, skip decision and
//                 multi-cycle MUL / ROTN behind a start/busy/valid handshake.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_seq_flags #(
  parameter int A   = 16,
  parameter int SHW = $clog2(A)
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         start,
  input  logic [3:0]   ALUOP,
  input  logic [A-1:0] op1,
  input  logic [A-1:0] op2,
  output logic [A-1:0] data,
  output logic         valid,
  output logic         busy,
  output logic         skip,
  output logic         E,
  output logic         Z,
  output logic         N,
  output logic         V
);

  localparam int CW = $clog2(A + 1);

  localparam logic [3:0] c_AND  = 4'b0000;
  localparam logic [3:0] c_ADD  = 4'b0001;
  localparam logic [3:0] c_CLA  = 4'b0010;
  localparam logic [3:0] c_CMA  = 4'b0011;
  localparam logic [3:0] c_CIR  = 4'b0100;
  localparam logic [3:0] c_CIL  = 4'b0101;
  localparam logic [3:0] c_INC  = 4'b0110;
  localparam logic [3:0] c_CLE  = 4'b0111;
  localparam logic [3:0] c_CME  = 4'b1000;
  localparam logic [3:0] c_SPA  = 4'b1001;
  localparam logic [3:0] c_SNA  = 4'b1010;
  localparam logic [3:0] c_SZA  = 4'b1011;
  localparam logic [3:0] c_SZE  = 4'b1100;
  localparam logic [3:0] c_LDA  = 4'b1101;
  localparam logic [3:0] c_MUL  = 4'b1110;
  localparam logic [3:0] c_ROTN = 4'b1111;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic           r_is_mul;
  logic [2*A-1:0] r_mc;
  logic [A-1:0]   r_mp;
  logic [2*A-1:0] r_prod;
  logic [A-1:0]   r_rot;
  logic           r_rote;

  logic [A:0]     w_sum;
  logic [A-1:0]   w_res;
  logic           w_e;
  logic           w_v;
  logic           w_skip;
  logic           w_zn;
  logic [SHW-1:0] w_amt;
  logic           w_multi;
  logic [2*A-1:0] w_prod;
  logic [A-1:0]   w_fin_data;
  logic           w_fin_e;

  // Single-cycle result, evaluated from the live inputs for the accepting edge.
  always_comb begin
    w_sum  = {1'b0, op1} + {1'b0, op2};
    w_res  = data;
    w_e    = E;
    w_v    = V;
    w_skip = 1'b0;
    w_zn   = 1'b0;
    case (ALUOP)
      c_AND: begin w_res = op1 & op2; w_zn = 1'b1; end
      c_ADD: begin
        w_res = w_sum[A-1:0];
        w_e   = w_sum[A];
        w_v   = (op1[A-1] == op2[A-1]) && (w_sum[A-1] != op1[A-1]);
        w_zn  = 1'b1;
      end
      c_CLA: begin w_res = '0; w_zn = 1'b1; end
      c_CMA: begin w_res = ~op1; w_zn = 1'b1; end
      c_CIR: begin w_res = {E, op1[A-1:1]}; w_e = op1[0]; w_zn = 1'b1; end
      c_CIL: begin w_res = {op1[A-2:0], E}; w_e = op1[A-1]; w_zn = 1'b1; end
      c_INC: begin w_res = op1 + A'(1); w_zn = 1'b1; end
      c_CLE: w_e = 1'b0;
      c_CME: w_e = ~E;
      c_SPA: begin w_res = '0; w_skip = ~op1[A-1]; end
      c_SNA: begin w_res = '0; w_skip = op1[A-1]; end
      c_SZA: begin w_res = '0; w_skip = (op1 == '0); end
      c_SZE: begin w_res = '0; w_skip = ~E; end
      default: begin w_res = op1; w_zn = 1'b1; end  // LDA, and ROTN by zero
    endcase
  end

  assign w_amt      = op2[SHW-1:0];
  assign w_multi    = (ALUOP == c_MUL) || ((ALUOP == c_ROTN) && (w_amt != '0));
  assign w_prod     = r_prod + (r_mp[0] ? r_mc : '0);
  assign w_fin_data = r_is_mul ? w_prod[A-1:0] : {r_rote, r_rot[A-1:1]};
  assign w_fin_e    = r_is_mul ? (|w_prod[2*A-1:A]) : r_rot[0];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_is_mul <= 1'b0;
      r_mc     <= '0;
      r_mp     <= '0;
      r_prod   <= '0;
      r_rot    <= '0;
      r_rote   <= 1'b0;
      data     <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      skip     <= 1'b0;
      E        <= 1'b0;
      Z        <= 1'b0;
      N        <= 1'b0;
      V        <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_multi) begin
              r_state  <= S_RUN;
              busy     <= 1'b1;
              r_is_mul <= (ALUOP == c_MUL);
              r_cnt    <= (ALUOP == c_MUL) ? CW'(A) : CW'(w_amt);
              r_mc     <= {{A{1'b0}}, op1};
              r_mp     <= op2;
              r_prod   <= '0;
              r_rot    <= op1;
              r_rote   <= E;
            end else begin
              data  <= w_res;
              E     <= w_e;
              V     <= w_v;
              skip  <= w_skip;
              valid <= 1'b1;
              if (w_zn) begin
                Z <= (w_res == '0);
                N <= w_res[A-1];
              end
            end
          end
        end
        default: begin
          r_cnt  <= r_cnt - CW'(1);
          r_prod <= w_prod;
          r_mc   <= r_mc << 1;
          r_mp   <= r_mp >> 1;
          r_rot  <= {r_rote, r_rot[A-1:1]};
          r_rote <= r_rot[0];
          if (r_cnt == CW'(1)) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            valid   <= 1'b1;
            data    <= w_fin_data;
            E       <= w_fin_e;
            Z       <= (w_fin_data == '0);
            N       <= w_fin_data[A-1];
            skip    <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_flags.sv
// Testbench for alu_seq_flags: directed cases plus randomized ops against a
// behavioural model; a second instance at A=8 covers the narrow MUL case.
`default_nettype none

module tb_alu_seq_flags;

  logic        CLK = 1'b0;
  logic        RST_N, start;
  logic [3:0]  ALUOP;
  logic [15:0] op1, op2, data;
  logic        valid, busy, skip, E, Z, N, V;

  logic        rst8_n, start8;
  logic [3:0]  aluop8;
  logic [7:0]  a8, b8, data8;
  logic        valid8, busy8, skip8, e8, z8, n8, v8;

  alu_seq_flags #(.A(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .ALUOP(ALUOP), .op1(op1), .op2(op2),
    .data(data), .valid(valid), .busy(busy), .skip(skip), .E(E), .Z(Z), .N(N), .V(V)
  );

  alu_seq_flags #(.A(8)) dut8 (
    .CLK(CLK), .RST_N(rst8_n), .start(start8), .ALUOP(aluop8), .op1(a8), .op2(b8),
    .data(data8), .valid(valid8), .busy(busy8), .skip(skip8), .E(e8), .Z(z8), .N(n8), .V(v8)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] m_data;
  logic        m_e, m_z, m_n, m_v;
  logic [15:0] exp_data;
  logic        exp_e, exp_z, exp_n, exp_v, exp_skip;
  int          exp_lat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: each op written from its arithmetic meaning.
  task automatic model_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s, x;
    logic [33:0] xx;
    logic [31:0] p;
    int          n;
    logic        wr;
    exp_data = m_data; exp_e = m_e; exp_v = m_v; exp_skip = 1'b0; exp_lat = 1; wr = 1'b1;
    case (op)
      4'd0:  exp_data = a & b;
      4'd1:  begin
        s = {1'b0, a} + {1'b0, b};
        exp_data = s[15:0]; exp_e = s[16];
        exp_v = (a[15] == b[15]) && (s[15] != a[15]);
      end
      4'd2:  exp_data = 16'h0;
      4'd3:  exp_data = ~a;
      4'd4:  begin exp_data = {m_e, a[15:1]}; exp_e = a[0]; end
      4'd5:  begin exp_data = {a[14:0], m_e}; exp_e = a[15]; end
      4'd6:  exp_data = a + 16'd1;
      4'd7:  begin exp_e = 1'b0; wr = 1'b0; end
      4'd8:  begin exp_e = ~m_e; wr = 1'b0; end
      4'd9:  begin exp_data = 16'h0; exp_skip = ~a[15]; wr = 1'b0; end
      4'd10: begin exp_data = 16'h0; exp_skip = a[15]; wr = 1'b0; end
      4'd11: begin exp_data = 16'h0; exp_skip = (a == 16'h0); wr = 1'b0; end
      4'd12: begin exp_data = 16'h0; exp_skip = (m_e == 1'b0); wr = 1'b0; end
      4'd13: exp_data = a;
      4'd14: begin
        p = 32'(a) * 32'(b);
        exp_data = p[15:0]; exp_e = |p[31:16]; exp_lat = 17;
      end
      default: begin
        // rotate the 17-bit value {E,op1} right by n
        n = int'(b[3:0]);
        x = {m_e, a};
        xx = {x, x} >> n;
        exp_data = xx[15:0]; exp_e = xx[16]; exp_lat = n + 1;
      end
    endcase
    exp_z = wr ? (exp_data == 16'h0) : m_z;
    exp_n = wr ? exp_data[15] : m_n;
    m_data = exp_data; m_e = exp_e; m_z = exp_z; m_n = exp_n; m_v = exp_v;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_data"}, data, exp_data);
    chk({tag, "_E"}, E, exp_e);
    chk({tag, "_Z"}, Z, exp_z);
    chk({tag, "_N"}, N, exp_n);
    chk({tag, "_V"}, V, exp_v);
    chk({tag, "_skip"}, skip, exp_skip);
  endtask

  task automatic do_op(input string tag, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b);
    int k, nbusy;
    model_op(op, a, b);
    @(negedge CLK);
    start = 1'b1; ALUOP = op; op1 = a; op2 = b;
    @(posedge CLK); #1;
    start = 1'b0; k = 1; nbusy = 0;
    while (!valid && k < 40) begin
      if (busy) nbusy++;
      @(posedge CLK); #1;
      k++;
    end
    chk({tag, "_lat"}, k, exp_lat);
    chk({tag, "_busycyc"}, nbusy, exp_lat - 1);
    chk({tag, "_busy0"}, busy, 1'b0);
    check_outputs(tag);
  endtask

  task automatic model_reset();
    m_data = 16'h0; m_e = 1'b0; m_z = 1'b0; m_n = 1'b0; m_v = 1'b0;
  endtask

  initial begin
    int k, nval;
    logic [15:0] prev, x, y;
    logic [15:0] mp;

    RST_N = 1'b0; start = 1'b0; ALUOP = 4'h0; op1 = 16'h0; op2 = 16'h0;
    rst8_n = 1'b0; start8 = 1'b0; aluop8 = 4'h0; a8 = 8'h0; b8 = 8'h0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_data", data, 16'h0);
    chk("rst_flags", {valid, busy, skip, E, Z, N, V}, 7'h0);
    @(negedge CLK);
    RST_N = 1'b1; rst8_n = 1'b1;

    // ADD carry/zero then signed overflow
    do_op("add1", 4'd1, 16'hFFFF, 16'h0001);
    chk("add1_Zconst", Z, 1'b1);
    do_op("add2", 4'd1, 16'h7FFF, 16'h0001);
    chk("add2_Vconst", V, 1'b1);

    // MUL
    do_op("mul1", 4'd14, 16'h0123, 16'h0045);
    chk("mul1_const", data, 16'h4E6F);
    do_op("mul2", 4'd14, 16'hFFFF, 16'h0002);

    // ROTN
    do_op("cle", 4'd7, 16'h0, 16'h0);
    do_op("rot3", 4'd15, 16'h0001, 16'h0003);
    chk("rot3_const", data, 16'h4000);
    do_op("rot1", 4'd15, 16'h0001, 16'h0001);
    do_op("rot0", 4'd15, 16'h0001, 16'h0000);

    // start ignored while busy, then accepted in the valid cycle
    prev = m_data;
    model_op(4'd14, 16'h0BCD, 16'h1234);
    @(negedge CLK);
    start = 1'b1; ALUOP = 4'd14; op1 = 16'h0BCD; op2 = 16'h1234;
    @(posedge CLK); #1;
    ALUOP = 4'd0; op1 = 16'($urandom); op2 = 16'($urandom); k = 1;
    while (!valid && k < 40) begin
      chk("ign_hold", data, prev);
      @(posedge CLK); #1;
      k++;
      if (!valid) begin op1 = 16'($urandom); op2 = 16'($urandom); end
    end
    chk("ign_lat", k, 17);
    check_outputs("ign_mul");
    x = 16'hF0A5; y = 16'h3C3C;
    op1 = x; op2 = y;
    model_op(4'd0, x, y);
    @(posedge CLK); #1;
    start = 1'b0;
    chk("b2b_valid", valid, 1'b1);
    check_outputs("b2b_and");

    // reset in the middle of a MUL
    @(negedge CLK);
    start = 1'b1; ALUOP = 4'd14; op1 = 16'h1357; op2 = 16'h9BDF;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    RST_N = 1'b0;
    #1;
    chk("mrst_data", data, 16'h0);
    chk("mrst_flags", {valid, busy, skip, E, Z, N, V}, 7'h0);
    model_reset();
    nval = 0;
    repeat (3) begin @(posedge CLK); #1; if (valid) nval++; end
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (20) begin @(posedge CLK); #1; if (valid) nval++; end
    chk("mrst_novalid", nval, 0);
    chk("mrst_busy", busy, 1'b0);
    do_op("cil", 4'd5, 16'h8000, 16'h0000);
    chk("cil_Econst", E, 1'b1);

    // skip ops
    do_op("sza", 4'd11, 16'h0000, 16'h1111);
    chk("sza_const", skip, 1'b1);
    do_op("spa", 4'd9, 16'h8000, 16'h0000);

    // randomized traffic
    for (int i = 0; i < 120; i++) begin
      logic [3:0]  op;
      logic [15:0] ra, rb;
      op = 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      rb = 16'($urandom);
      do_op("rnd", op, ra, rb);
    end

    // A=8 instance: MUL FF*FF plus random products
    for (int i = 0; i < 6; i++) begin
      logic [7:0] ma, mb;
      ma = (i == 0) ? 8'hFF : 8'($urandom);
      mb = (i == 0) ? 8'hFF : 8'($urandom);
      mp = 16'(ma) * 16'(mb);
      @(negedge CLK);
      start8 = 1'b1; aluop8 = 4'd14; a8 = ma; b8 = mb;
      @(posedge CLK); #1;
      start8 = 1'b0; k = 1;
      while (!valid8 && k < 40) begin @(posedge CLK); #1; k++; end
      chk("mul8_lat", k, 9);
      chk("mul8_data", data8, mp[7:0]);
      chk("mul8_E", e8, |mp[15:8]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
